// File: rtl/micro_pkg.sv
// Shared constants and types for the micro sequencer.
// Opcodes, control-word bit positions and FSM state encoding.
package micro_pkg;

  localparam int MS_W = 3;
  localparam int CW_W = 17;
  localparam int MAX_STEP = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int HLT_B = 16;
  localparam int WE_B  = 15;
  localparam int OE_B  = 14;
  localparam int MI_B  = 13;
  localparam int AI_B  = 12;
  localparam int BI_B  = 11;
  localparam int AO_B  = 10;
  localparam int BO_B  = 9;
  localparam int EO_B  = 8;
  localparam int SUB_B = 7;
  localparam int OI_B  = 6;
  localparam int CE_B  = 5;
  localparam int J_B   = 4;
  localparam int CO_B  = 3;
  localparam int II_B  = 2;
  localparam int IO_B  = 1;
  localparam int FI_B  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [CW_W-1:0] signals;
    logic            last;
  } rom_out_t;

  function automatic logic [CW_W-1:0] sb(input int b);
    return CW_W'(1) << b;
  endfunction

endpackage

// File: rtl/micro_rom.sv
// Microcode table: control word and final-step flag
// for each (opcode, step, flags) combination.
module micro_rom
  import micro_pkg::*;
(
  input  logic [3:0]      opcode,
  input  logic [MS_W-1:0] micro,
  input  logic            FZ,
  input  logic            FC,
  output rom_out_t        rom
);

  always_comb begin
    rom.signals = '0;
    rom.last    = 1'b0;
    case (micro)
      MS_W'(0): rom.signals = sb(CO_B) | sb(MI_B);
      MS_W'(1): rom.signals = sb(OE_B) | sb(II_B) | sb(CE_B);
      MS_W'(2): begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            rom.signals = sb(IO_B) | sb(MI_B);
          OP_LDI: begin
            rom.signals = sb(IO_B) | sb(AI_B);
            rom.last    = 1'b1;
          end
          OP_JMP: begin
            rom.signals = sb(IO_B) | sb(J_B);
            rom.last    = 1'b1;
          end
          OP_JC: begin
            if (FC) rom.signals = sb(IO_B) | sb(J_B);
            rom.last = 1'b1;
          end
          OP_JZ: begin
            if (FZ) rom.signals = sb(IO_B) | sb(J_B);
            rom.last = 1'b1;
          end
          OP_OUT: begin
            rom.signals = sb(AO_B) | sb(OI_B);
            rom.last    = 1'b1;
          end
          OP_HLT: begin
            rom.signals = sb(HLT_B);
            rom.last    = 1'b1;
          end
          // NOP, undefined, and untaken branches end on a blank T2
          default: rom.last = 1'b1;
        endcase
      end
      MS_W'(3): begin
        case (opcode)
          OP_LDA: begin
            rom.signals = sb(OE_B) | sb(AI_B);
            rom.last    = 1'b1;
          end
          OP_ADD, OP_SUB:
            rom.signals = sb(OE_B) | sb(BI_B);
          OP_STA: begin
            rom.signals = sb(AO_B) | sb(WE_B);
            rom.last    = 1'b1;
          end
          default: rom.last = 1'b1;
        endcase
      end
      MS_W'(MAX_STEP): begin
        rom.last = 1'b1;
        case (opcode)
          OP_ADD:
            rom.signals = sb(EO_B) | sb(AI_B) | sb(FI_B);
          OP_SUB:
            rom.signals = sb(EO_B) | sb(AI_B)
                        | sb(FI_B) | sb(SUB_B);
          default: rom.signals = '0;
        endcase
      end
      default: rom.last = 1'b1;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Run/step/halt FSM and micro-step counter driving
// the datapath control word from micro_rom.
module micro_sequencer #(
  parameter int STEP_W = 3,
  parameter int SIG_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_req,
  input  logic [3:0]        opcode,
  input  logic              FZ,
  input  logic              FC,
  output logic [SIG_W-1:0]  signals,
  output logic [STEP_W-1:0] micro,
  output logic [1:0]        state_o,
  output logic              instr_done,
  output logic              halted
);
  import micro_pkg::*;

  state_t   state;
  rom_out_t rom;

  micro_rom u_rom (
    .opcode (opcode),
    .micro  (MS_W'(micro)),
    .FZ     (FZ),
    .FC     (FC),
    .rom    (rom)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      micro <= '0;
    end else begin
      case (state)
        IDLE: begin
          micro <= '0;
          if (run || step_req) state <= EXEC;
        end
        EXEC: begin
          if (rom.last) begin
            micro <= '0;
            if (opcode == OP_HLT) state <= HALT;
            else if (!run)        state <= IDLE;
          end else begin
            micro <= micro + STEP_W'(1);
          end
        end
        HALT: micro <= '0;
        default: begin
          state <= IDLE;
          micro <= '0;
        end
      endcase
    end
  end

  always_comb begin
    signals    = '0;
    instr_done = 1'b0;
    if (!rst) begin
      case (state)
        EXEC: begin
          signals    = SIG_W'(rom.signals);
          instr_done = rom.last;
        end
        HALT:    signals = SIG_W'(sb(HLT_B));
        default: signals = '0;
      endcase
    end
  end

  assign state_o = state;
  assign halted  = (state == HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: stimulus pushes expected
// per-cycle outputs, an independent monitor pops and compares.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step_req = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        FZ = 1'b0;
  logic        FC = 1'b0;
  logic [16:0] signals;
  logic [2:0]  micro;
  logic [1:0]  state_o;
  logic        instr_done;
  logic        halted;

  typedef struct {
    int          id;
    logic [16:0] sig;
    logic [2:0]  m;
    logic [1:0]  st;
    logic        done;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   vec = 0;

  logic       n_rst = 1'b1;
  logic       n_run = 1'b0;
  logic       n_step = 1'b0;
  logic [3:0] n_op = 4'd0;
  logic       n_fz = 1'b0;
  logic       n_fc = 1'b0;

  micro_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step_req   (step_req),
    .opcode     (opcode),
    .FZ         (FZ),
    .FC         (FC),
    .signals    (signals),
    .micro      (micro),
    .state_o    (state_o),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [16:0] s, input logic [2:0] m,
                     input logic [1:0] st, input logic d);
    exp_t e;
    @(negedge clk);
    rst      = n_rst;
    run      = n_run;
    step_req = n_step;
    opcode   = n_op;
    FZ       = n_fz;
    FC       = n_fc;
    e.id   = vec;
    e.sig  = s;
    e.m    = m;
    e.st   = st;
    e.done = d;
    e.hlt  = (st == 2'd2);
    q.push_back(e);
    vec++;
  endtask

  task automatic idle();
    cyc(17'h0, 3'd0, 2'd0, 1'b0);
  endtask

  task automatic fetch();
    cyc(17'h02008, 3'd0, 2'd1, 1'b0);
    cyc(17'h04024, 3'd1, 2'd1, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (signals !== e.sig || micro !== e.m || state_o !== e.st
            || instr_done !== e.done || halted !== e.hlt) begin
          n_fail++;
          $display("FAIL vec%0d: got sig=%05h m=%0d st=%0d done=%0b hlt=%0b, want sig=%05h m=%0d st=%0d done=%0b hlt=%0b",
                   e.id, signals, micro, state_o, instr_done, halted,
                   e.sig, e.m, e.st, e.done, e.hlt);
        end
      end
    end
  end

  initial begin : stim
    int budget;
    // reset held
    idle();
    // LDI free-run, back-to-back into ADD then SUB
    n_rst = 1'b0; n_run = 1'b1; n_op = 4'd5;
    idle();
    fetch();
    cyc(17'h01002, 3'd2, 2'd1, 1'b1);
    n_op = 4'd2;
    fetch();
    cyc(17'h02002, 3'd2, 2'd1, 1'b0);
    cyc(17'h04800, 3'd3, 2'd1, 1'b0);
    cyc(17'h01101, 3'd4, 2'd1, 1'b1);
    n_op = 4'd3;
    fetch();
    cyc(17'h02002, 3'd2, 2'd1, 1'b0);
    cyc(17'h04800, 3'd3, 2'd1, 1'b0);
    n_run = 1'b0;
    cyc(17'h01181, 3'd4, 2'd1, 1'b1);
    idle();
    // single-step LDA with ignored extra step_req
    n_op = 4'd1; n_step = 1'b1;
    idle();
    cyc(17'h02008, 3'd0, 2'd1, 1'b0);
    n_step = 1'b0;
    cyc(17'h04024, 3'd1, 2'd1, 1'b0);
    n_step = 1'b1;
    cyc(17'h02002, 3'd2, 2'd1, 1'b0);
    cyc(17'h05000, 3'd3, 2'd1, 1'b1);
    n_step = 1'b0;
    idle();
    idle();
    // STA
    n_op = 4'd4; n_step = 1'b1;
    idle();
    n_step = 1'b0;
    fetch();
    cyc(17'h02002, 3'd2, 2'd1, 1'b0);
    cyc(17'h08400, 3'd3, 2'd1, 1'b1);
    idle();
    // JC untaken / taken
    n_op = 4'd7; n_fc = 1'b0; n_fz = 1'b1; n_step = 1'b1;
    idle();
    n_step = 1'b0;
    fetch();
    cyc(17'h00000, 3'd2, 2'd1, 1'b1);
    n_fc = 1'b1; n_fz = 1'b0; n_step = 1'b1;
    idle();
    n_step = 1'b0;
    fetch();
    cyc(17'h00012, 3'd2, 2'd1, 1'b1);
    // JZ untaken / taken
    n_op = 4'd8; n_fz = 1'b0; n_fc = 1'b1; n_step = 1'b1;
    idle();
    n_step = 1'b0;
    fetch();
    cyc(17'h00000, 3'd2, 2'd1, 1'b1);
    n_fz = 1'b1; n_fc = 1'b0; n_step = 1'b1;
    idle();
    n_step = 1'b0;
    fetch();
    cyc(17'h00012, 3'd2, 2'd1, 1'b1);
    // undefined opcode behaves as NOP
    n_op = 4'd11; n_step = 1'b1;
    idle();
    n_step = 1'b0;
    fetch();
    cyc(17'h00000, 3'd2, 2'd1, 1'b1);
    // OUT
    n_op = 4'd14; n_step = 1'b1;
    idle();
    n_step = 1'b0;
    fetch();
    cyc(17'h00440, 3'd2, 2'd1, 1'b1);
    // HLT, then sticky HALT
    n_op = 4'd15; n_run = 1'b1;
    idle();
    fetch();
    cyc(17'h10000, 3'd2, 2'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      n_step = i[0];
      cyc(17'h10000, 3'd0, 2'd2, 1'b0);
    end
    n_step = 1'b0; n_rst = 1'b1; n_run = 1'b0;
    cyc(17'h00000, 3'd0, 2'd2, 1'b0);
    n_rst = 1'b0;
    idle();
    // reset mid-ADD at micro 3; rst beats step_req
    n_op = 4'd2; n_run = 1'b1;
    idle();
    fetch();
    cyc(17'h02002, 3'd2, 2'd1, 1'b0);
    n_rst = 1'b1;
    cyc(17'h00000, 3'd3, 2'd1, 1'b0);
    n_run = 1'b0; n_step = 1'b1;
    idle();
    n_rst = 1'b0; n_step = 1'b0;
    idle();
    idle();
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
